// File: rtl/cajero_pkg.sv
// cajero_pkg: shared state and transaction-type definitions for the ATM controller
package cajero_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        INGRESO_PIN,
        ESPERA_MONTO,
        FIN,
        BLOQUEADO
    } estado_t;

    typedef logic [1:0] tipo_t;

    localparam tipo_t TT_DEPOSITO = 2'b00;
    localparam tipo_t TT_RETIRO   = 2'b01;
    localparam tipo_t TT_CONSULTA = 2'b10;
    localparam tipo_t TT_INVALIDO = 2'b11;

endpackage

// File: rtl/cajero_pin_buffer.sv
// cajero_pin_buffer: MS-first PIN digit shift register with compare strobe
module cajero_pin_buffer #(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    output logic                    cmp_valid,
    output logic                    match
);

    localparam int CW = $clog2(PIN_DIGITS + 1);

    logic [4*PIN_DIGITS-1:0] sr_q;
    logic [4*PIN_DIGITS-1:0] sr_d;
    logic [CW-1:0]           cnt_q;

    // Assembled PIN includes the digit arriving on this edge, so the last strobe compares in place
    always_comb begin
        sr_d      = (sr_q << 4) | (4*PIN_DIGITS)'(digito);
        cmp_valid = en && (cnt_q == CW'(PIN_DIGITS - 1));
        match     = (sr_d == pin_ref);
    end

    // Shift digits in; a compare or a discard request empties the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr || cmp_valid) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (en) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cajero_multi_ctrl.sv
// cajero_multi_ctrl: parametrised ATM session controller (PIN, deposit, withdrawal, inquiry)
module cajero_multi_ctrl
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS    = 4,
    parameter int MAX_INTENTOS  = 3,
    parameter int MONTO_W       = 32,
    parameter int BAL_W         = 64,
    parameter int LIMITE_RETIRO = 500000,
    parameter int TIMEOUT_CYC   = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tarjeta_recibida,
    input  logic [1:0]                        tipo_trans,
    input  logic                              digito_stb,
    input  logic [3:0]                        digito,
    input  logic [4*PIN_DIGITS-1:0]           pin_correcto,
    input  logic                              monto_stb,
    input  logic [MONTO_W-1:0]                monto,
    input  logic [BAL_W-1:0]                  balance_inicial,
    input  logic                              fin_dia,
    output logic                              balance_stb,
    output logic [BAL_W-1:0]                  balance_actualizado,
    output logic                              entregar_dinero,
    output logic                              pin_incorrecto,
    output logic                              advertencia,
    output logic                              bloqueo,
    output logic                              fondos_insuficientes,
    output logic                              limite_excedido,
    output logic                              timeout,
    output logic [$clog2(MAX_INTENTOS+1)-1:0] intentos_restantes
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0]    MAXI  = IW'(MAX_INTENTOS);
    localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BAL_W:0]   LIM   = (BAL_W+1)'(LIMITE_RETIRO);

    estado_t                 state_q;
    logic                    tar_q;
    tipo_t                   tipo_q;
    logic [4*PIN_DIGITS-1:0] pin_q;
    logic [BAL_W-1:0]        bal_q;
    logic [BAL_W-1:0]        total_q;
    logic [IW-1:0]           fallos_q;
    logic [TW-1:0]           idle_q;

    logic [BAL_W:0]          monto_x;
    logic [BAL_W:0]          dep_sum;
    logic [BAL_W:0]          ret_sum;
    logic [BAL_W-1:0]        bal_d;
    logic [IW-1:0]           fallos_d;
    logic [IW-1:0]           rest_d;
    logic                    activo;
    logic                    strobe;
    logic                    tmo;
    logic                    en_dig;
    logic                    cmp_valid;
    logic                    match;

    // Arithmetic and condition terms; a same-cycle fin_dia clears the total before the limit test
    always_comb begin
        monto_x  = (BAL_W+1)'(monto);
        dep_sum  = {1'b0, bal_q} + monto_x;
        ret_sum  = (fin_dia ? '0 : {1'b0, total_q}) + monto_x;
        bal_d    = bal_q - monto_x[BAL_W-1:0];
        fallos_d = fallos_q + 1'b1;
        rest_d   = MAXI - fallos_d;
        activo   = (state_q == INGRESO_PIN) || (state_q == ESPERA_MONTO);
        strobe   = digito_stb || monto_stb;
        tmo      = !strobe && (idle_q == TLAST);
        en_dig   = (state_q == INGRESO_PIN) && tarjeta_recibida && digito_stb;
    end

    cajero_pin_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_pin (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_q != INGRESO_PIN),
        .en        (en_dig),
        .digito    (digito),
        .pin_ref   (pin_q),
        .cmp_valid (cmp_valid),
        .match     (match)
    );

    // Session FSM with registered outputs, attempt tracking, withdrawal total and idle timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= ESPERA_TARJETA;
            tar_q                <= 1'b0;
            tipo_q               <= TT_DEPOSITO;
            pin_q                <= '0;
            bal_q                <= '0;
            total_q              <= '0;
            fallos_q             <= '0;
            idle_q               <= '0;
            balance_stb          <= 1'b0;
            balance_actualizado  <= '0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
            limite_excedido      <= 1'b0;
            timeout              <= 1'b0;
            intentos_restantes   <= MAXI;
        end else begin
            tar_q                <= tarjeta_recibida;
            idle_q               <= (activo && !strobe) ? idle_q + 1'b1 : '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            fondos_insuficientes <= 1'b0;
            limite_excedido      <= 1'b0;
            timeout              <= 1'b0;
            if (fin_dia) total_q <= '0;
            case (state_q)
                ESPERA_TARJETA: begin
                    if (tarjeta_recibida && !tar_q && tipo_trans != TT_INVALIDO) begin
                        tipo_q  <= tipo_trans;
                        pin_q   <= pin_correcto;
                        bal_q   <= balance_inicial;
                        state_q <= INGRESO_PIN;
                    end
                end
                INGRESO_PIN: begin
                    if (!tarjeta_recibida) begin
                        state_q <= ESPERA_TARJETA;
                    end else if (cmp_valid && match) begin
                        fallos_q           <= '0;
                        intentos_restantes <= MAXI;
                        advertencia        <= 1'b0;
                        if (tipo_q == TT_CONSULTA) begin
                            balance_stb         <= 1'b1;
                            balance_actualizado <= bal_q;
                            state_q             <= FIN;
                        end else begin
                            state_q <= ESPERA_MONTO;
                        end
                    end else if (cmp_valid) begin
                        pin_incorrecto     <= 1'b1;
                        fallos_q           <= fallos_d;
                        intentos_restantes <= rest_d;
                        if (rest_d == '0) begin
                            bloqueo     <= 1'b1;
                            advertencia <= 1'b0;
                            state_q     <= BLOQUEADO;
                        end else if (rest_d == IW'(1)) begin
                            advertencia <= 1'b1;
                        end
                    end else if (tmo) begin
                        timeout <= 1'b1;
                        state_q <= FIN;
                    end
                end
                ESPERA_MONTO: begin
                    if (!tarjeta_recibida) begin
                        state_q <= ESPERA_TARJETA;
                    end else if (monto_stb) begin
                        state_q <= FIN;
                        if (tipo_q == TT_DEPOSITO) begin
                            balance_stb         <= 1'b1;
                            balance_actualizado <= dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
                        end else if (monto_x > {1'b0, bal_q}) begin
                            fondos_insuficientes <= 1'b1;
                        end else if (ret_sum > LIM) begin
                            limite_excedido <= 1'b1;
                        end else begin
                            bal_q               <= bal_d;
                            balance_actualizado <= bal_d;
                            total_q             <= ret_sum[BAL_W-1:0];
                            entregar_dinero     <= 1'b1;
                            balance_stb         <= 1'b1;
                        end
                    end else if (tmo) begin
                        timeout <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!tarjeta_recibida) state_q <= ESPERA_TARJETA;
                end
                BLOQUEADO: begin
                    state_q <= BLOQUEADO;
                end
                default: begin
                    state_q <= ESPERA_TARJETA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cajero_multi_ctrl.sv
// tb_cajero_multi_ctrl: directed self-checking bench for the ATM controller
module tb_cajero_multi_ctrl;
    import cajero_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic [1:0]  tipo_trans;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [15:0] pin_correcto;
    logic        monto_stb;
    logic [31:0] monto;
    logic [63:0] balance_inicial;
    logic        fin_dia;
    logic        balance_stb;
    logic [63:0] balance_actualizado;
    logic        entregar_dinero;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        fondos_insuficientes;
    logic        limite_excedido;
    logic        timeout;
    logic [1:0]  intentos_restantes;

    int n_chk  = 0;
    int n_pass = 0;

    cajero_multi_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin_correcto         (pin_correcto),
        .monto_stb            (monto_stb),
        .monto                (monto),
        .balance_inicial      (balance_inicial),
        .fin_dia              (fin_dia),
        .balance_stb          (balance_stb),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .fondos_insuficientes (fondos_insuficientes),
        .limite_excedido      (limite_excedido),
        .timeout              (timeout),
        .intentos_restantes   (intentos_restantes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic card(input logic [1:0] t, input logic [63:0] b);
        tipo_trans       = t;
        balance_inicial  = b;
        tarjeta_recibida = 1'b1;
        tick();
    endtask

    task automatic pull();
        tarjeta_recibida = 1'b0;
        tick();
    endtask

    task automatic dig(input logic [3:0] d);
        digito_stb = 1'b1;
        digito     = d;
        tick();
        digito_stb = 1'b0;
    endtask

    task automatic pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) dig(p[4*i +: 4]);
    endtask

    task automatic amt(input logic [31:0] m, input logic fd);
        monto     = m;
        fin_dia   = fd;
        monto_stb = 1'b1;
        tick();
        monto_stb = 1'b0;
        fin_dia   = 1'b0;
    endtask

    function automatic logic [4:0] pulses();
        return {entregar_dinero, balance_stb, fondos_insuficientes, limite_excedido, timeout};
    endfunction

    initial begin
        reset = 1'b1; tarjeta_recibida = 1'b0; tipo_trans = 2'b00; digito_stb = 1'b0;
        digito = 4'h0; pin_correcto = 16'h1234; monto_stb = 1'b0; monto = '0;
        balance_inicial = '0; fin_dia = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_intentos", 64'(intentos_restantes), 64'd3);
        check("rst_flags", {59'd0, pulses()}, 64'd0);
        check("rst_bloqueo", 64'(bloqueo), 64'd0);
        check("rst_balance", balance_actualizado, 64'd0);

        card(TT_RETIRO, 64'd1000); pin(16'h1234); amt(32'd300, 1'b0);
        check("ret_pulses", {59'd0, pulses()}, 64'b11000);
        check("ret_balance", balance_actualizado, 64'd700);
        tick();
        check("ret_pulse_end", {59'd0, pulses()}, 64'd0);
        pull();

        card(TT_RETIRO, 64'd5000);
        pin(16'h1111);
        check("pin1_inc", 64'(pin_incorrecto), 64'd1);
        check("pin1_rest", 64'(intentos_restantes), 64'd2);
        check("pin1_adv", 64'(advertencia), 64'd0);
        pin(16'h2222);
        check("pin2_inc", 64'(pin_incorrecto), 64'd1);
        check("pin2_rest", 64'(intentos_restantes), 64'd1);
        check("pin2_adv", 64'(advertencia), 64'd1);
        pin(16'h1234);
        check("pin3_inc", 64'(pin_incorrecto), 64'd0);
        check("pin3_rest", 64'(intentos_restantes), 64'd3);
        check("pin3_adv", 64'(advertencia), 64'd0);
        pull();
        check("abort_pulses", {59'd0, pulses()}, 64'd0);

        fin_dia = 1'b1; tick(); fin_dia = 1'b0;
        card(TT_RETIRO, 64'd1000000); pin(16'h1234); amt(32'd400000, 1'b0);
        check("lim1_ent", 64'(entregar_dinero), 64'd1);
        check("lim1_bal", balance_actualizado, 64'd600000);
        pull();
        card(TT_RETIRO, 64'd600000); pin(16'h1234); amt(32'd200000, 1'b0);
        check("lim2_pulses", {59'd0, pulses()}, 64'b00010);
        check("lim2_bal", balance_actualizado, 64'd600000);
        pull();
        card(TT_RETIRO, 64'd600000); pin(16'h1234); amt(32'd200000, 1'b1);
        check("lim3_pulses", {59'd0, pulses()}, 64'b11000);
        check("lim3_bal", balance_actualizado, 64'd400000);
        pull();
        card(TT_RETIRO, 64'd400000); pin(16'h1234); amt(32'd300000, 1'b0);
        check("lim_edge_pulses", {59'd0, pulses()}, 64'b11000);
        check("lim_edge_bal", balance_actualizado, 64'd100000);
        pull();

        card(TT_RETIRO, 64'd100); pin(16'h1234); amt(32'd101, 1'b0);
        check("fondos_pulses", {59'd0, pulses()}, 64'b00100);
        pull();
        fin_dia = 1'b1; tick(); fin_dia = 1'b0;
        card(TT_RETIRO, 64'd100); pin(16'h1234); amt(32'd0, 1'b0);
        check("cero_pulses", {59'd0, pulses()}, 64'b11000);
        check("cero_bal", balance_actualizado, 64'd100);
        pull();

        card(TT_DEPOSITO, 64'hFFFF_FFFF_FFFF_FFFF); pin(16'h1234); amt(32'd1, 1'b0);
        check("dep_pulses", {59'd0, pulses()}, 64'b01000);
        check("dep_sat", balance_actualizado, 64'hFFFF_FFFF_FFFF_FFFF);
        pull();
        card(TT_DEPOSITO, 64'd250); pin(16'h1234); amt(32'd50, 1'b0);
        check("dep_bal", balance_actualizado, 64'd300);
        pull();

        card(TT_CONSULTA, 64'd12345); pin(16'h1234);
        check("cons_pulses", {59'd0, pulses()}, 64'b01000);
        check("cons_bal", balance_actualizado, 64'd12345);
        pull();

        card(TT_INVALIDO, 64'd0); pin(16'h0000);
        check("inval_inc", 64'(pin_incorrecto), 64'd0);
        check("inval_rest", 64'(intentos_restantes), 64'd3);
        pull();

        card(TT_RETIRO, 64'd50); dig(4'h1); dig(4'h2);
        repeat (999) tick();
        check("tmo_early", 64'(timeout), 64'd0);
        tick();
        check("tmo_pulse", 64'(timeout), 64'd1);
        check("tmo_rest", 64'(intentos_restantes), 64'd3);
        tick();
        check("tmo_end", 64'(timeout), 64'd0);
        pull();
        card(TT_CONSULTA, 64'd77); pin(16'h1234);
        check("tmo_after_bal", balance_actualizado, 64'd77);
        check("tmo_after_stb", 64'(balance_stb), 64'd1);
        pull();

        card(TT_RETIRO, 64'd0); pin(16'h1111); pin(16'h2222); pin(16'h3333);
        check("blk_inc", 64'(pin_incorrecto), 64'd1);
        check("blk_bloqueo", 64'(bloqueo), 64'd1);
        check("blk_rest", 64'(intentos_restantes), 64'd0);
        check("blk_adv", 64'(advertencia), 64'd0);
        pull();
        card(TT_CONSULTA, 64'd99); pin(16'h1234);
        check("blk_ignore", 64'(balance_stb), 64'd0);
        check("blk_hold", 64'(bloqueo), 64'd1);
        tarjeta_recibida = 1'b0;
        reset = 1'b1; #1;
        check("blk_reset", 64'(bloqueo), 64'd0);
        check("blk_reset_rest", 64'(intentos_restantes), 64'd3);
        tick(); reset = 1'b0; tick();

        card(TT_RETIRO, 64'd0); pin(16'h1111);
        check("mid_rest", 64'(intentos_restantes), 64'd2);
        dig(4'h1); dig(4'h2);
        #2 reset = 1'b1; tarjeta_recibida = 1'b0;
        #1;
        check("mid_async_rest", 64'(intentos_restantes), 64'd3);
        check("mid_async_flags", {57'd0, pin_incorrecto, advertencia, pulses()}, 64'd0);
        tick(); reset = 1'b0; tick();
        card(TT_CONSULTA, 64'd5); pin(16'h1234);
        check("mid_after_bal", balance_actualizado, 64'd5);
        pull();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cajero_multi_ctrl.md
Name: cajero_multi_ctrl

Overview:
Parametrised next-generation ATM transaction controller. Handles PIN length, attempt count, amount/balance widths and a cumulative withdrawal limit through parameters. Adds deposit and balance-inquiry modes, an end-of-day limit reset and an inactivity timeout. It sits between the card/keypad front end and the account store, and is exercised by a separate tester module.

Parameters:
PIN_DIGITS, 4, number of 4-bit digits in the PIN
MAX_INTENTOS, 3, wrong-PIN attempts before permanent block
MONTO_W, 32, amount width
BAL_W, 64, balance width (BAL_W >= MONTO_W)
LIMITE_RETIRO, 500000, max cumulative withdrawals between fin_dia pulses
TIMEOUT_CYC, 1000, idle cycles allowed in PIN/amount entry

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high; forces reset values immediately
tarjeta_recibida  in  1  card present (level); a session starts on the 0->1 edge
tipo_trans  in  2  00 deposit, 01 withdrawal, 10 inquiry, 11 invalid; sampled at session start
digito_stb  in  1  digito valid strobe
digito  in  4  keypad digit
pin_correcto  in  4*PIN_DIGITS  expected PIN, first digit in the MS nibble; sampled at session start
monto_stb  in  1  monto valid strobe
monto  in  MONTO_W  transaction amount
balance_inicial  in  BAL_W  account balance; sampled at session start
fin_dia  in  1  clears the cumulative withdrawal total
balance_stb  out  1  one-cycle pulse: balance_actualizado valid
balance_actualizado  out  BAL_W  resulting balance, held until the next update
entregar_dinero  out  1  one-cycle pulse: dispense
pin_incorrecto  out  1  one-cycle pulse per wrong PIN
advertencia  out  1  level: one attempt remaining
bloqueo  out  1  level: blocked until reset
fondos_insuficientes  out  1  one-cycle pulse
limite_excedido  out  1  one-cycle pulse
timeout  out  1  one-cycle pulse
intentos_restantes  out  $clog2(MAX_INTENTOS+1)  attempts remaining

Behaviour:
- Reset values: all outputs 0 except intentos_restantes=MAX_INTENTOS. Internal state: ESPERA_TARJETA; attempt counter, withdrawal total, timers and PIN buffer all 0.
- All outputs are registered. A pulse is high for the one cycle after the edge that sampled its triggering strobe.
- ESPERA_TARJETA:
  - On the tarjeta_recibida rising edge, capture tipo_trans, pin_correcto and balance_inicial, then go to INGRESO_PIN.
  - tipo 11: no state change, no outputs.
- INGRESO_PIN:
  - Each digito_stb shifts digito in MS-first; digit values 10-15 are accepted verbatim.
  - The PIN_DIGITS-th strobe compares the assembled PIN with the captured PIN, including the incoming digit, on the same edge.
  - Match: attempt counter=0, intentos_restantes=MAX_INTENTOS, advertencia=0.
    - Inquiry: pulse balance_stb with the captured balance, go to FIN.
    - Otherwise: go to ESPERA_MONTO.
  - Mismatch: pulse pin_incorrecto, counter+1, intentos_restantes-1, clear the buffer.
    - Remaining attempts==1: set advertencia.
    - Remaining attempts==0: set bloqueo, clear advertencia, go to BLOQUEADO.
    - Otherwise: stay in INGRESO_PIN.
  - monto_stb is ignored in this state.
- ESPERA_MONTO, on monto_stb (amount zero-extended to BAL_W), then go to FIN:
  - Deposit: balance+monto, saturating at 2^BAL_W-1; pulse balance_stb.
  - Withdrawal, checks in priority order:
    - monto>balance: pulse fondos_insuficientes.
    - total+monto>LIMITE_RETIRO: pulse limite_excedido.
    - Otherwise: balance-=monto, total+=monto, pulse entregar_dinero and balance_stb in the same cycle.
  - monto=0 is a valid transaction.
- FIN: wait for tarjeta_recibida=0, then go to ESPERA_TARJETA.
- Card removal during INGRESO_PIN or ESPERA_MONTO: abort to ESPERA_TARJETA. No output pulse; the partial PIN is discarded; the attempt counter is kept.
- Timeout:
  - The idle counter runs only in INGRESO_PIN and ESPERA_MONTO, and any strobe reloads it.
  - Reaching TIMEOUT_CYC: pulse timeout, discard the partial PIN, attempts unchanged, go to FIN.
- The attempt counter persists across sessions; only a correct PIN or reset clears it.
- BLOQUEADO: terminal; all strobes and card edges are ignored until reset.
- fin_dia clears the withdrawal total in any state. If it coincides with a withdrawal's monto_stb, the clear applies first.
- Reset mid-operation: immediate return to reset values; no pulse completes.

Decomposition:
- Package cajero_pkg: state enum (ESPERA_TARJETA, INGRESO_PIN, ESPERA_MONTO, FIN, BLOQUEADO) and tipo_trans codes TT_DEPOSITO, TT_RETIRO, TT_CONSULTA, TT_INVALIDO.
- Sub-module cajero_pin_buffer: digit shift register, digit counter, and a compare-valid/match output.

Test Plan:
- Withdrawal: balance=1000, PIN 1-2-3-4 correct, monto=300 -> entregar_dinero and balance_stb together, balance_actualizado=700.
- Wrong PIN x2, then correct, with MAX=3 -> pin_incorrecto twice, advertencia after the second, intentos_restantes 3->2->1->3, advertencia cleared.
- Wrong PIN x3 -> bloqueo=1; a new card plus correct PIN gives no response; reset -> bloqueo=0.
- Limit: LIMITE=500000, withdraw 400000 then 200000 in a second session -> limite_excedido, balance unchanged. Then fin_dia and retry -> entregar_dinero.
- Edges: balance=100, withdraw 101 -> fondos_insuficientes. Deposit of 1 at balance 2^64-1 -> balance stays 2^64-1. Inquiry -> balance_stb only, with the captured balance.
- Timeout / abort: 2 digits then TIMEOUT_CYC idle cycles -> timeout pulse, attempts unchanged. Card removed mid-amount entry -> no pulses. Reset asserted mid-PIN entry -> outputs return to reset values asynchronously.
